// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads instruction memory and feeds decode
// through a 2-entry FIFO. Optional pop counter enabled by the FETCH_PERF_CNT_EN macro.
module inst_fetch_ctrl #(
  parameter int          ADDR_W      = 16,
  parameter int          DATA_W      = 32,
  parameter int          RESET_PC    = 0,
  parameter int          LAST_ADDR   = 10,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count
`endif
);

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                done_q, done_d;

  // Two-slot FIFO: head feeds decode directly, tail holds the next word.
  logic                h_vld_q, h_vld_d;
  logic [DATA_W-1:0]   h_data_q, h_data_d;
  logic [ADDR_W-1:0]   h_pc_q, h_pc_d;
  logic                t_vld_q, t_vld_d;
  logic [DATA_W-1:0]   t_data_q, t_data_d;
  logic [ADDR_W-1:0]   t_pc_q, t_pc_d;

  logic pop;
  logic push;
  logic halt_word;
  logic start_ok;

  assign pop       = h_vld_q & inst_ready;
  assign halt_word = (imem_data[DATA_W-1 -: 6] == HALT_OPCODE);
  assign start_ok  = (state_q == S_IDLE) & start;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    done_d   = 1'b0;
    push     = 1'b0;
    h_vld_d  = h_vld_q;
    h_data_d = h_data_q;
    h_pc_d   = h_pc_q;
    t_vld_d  = t_vld_q;
    t_data_d = t_data_q;
    t_pc_d   = t_pc_q;

    if (pop) begin
      h_vld_d  = t_vld_q;
      h_data_d = t_data_q;
      h_pc_d   = t_pc_q;
      t_vld_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = START_PC;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (pc_q > LAST_PC) begin
          state_d = S_DRAIN;
        end else begin
          push = ~t_vld_q | pop;
          if (push) begin
            // Fill the head first so FIFO order is preserved after the pop shift.
            if (!h_vld_d) begin
              h_vld_d  = 1'b1;
              h_data_d = imem_data;
              h_pc_d   = pc_q;
            end else begin
              t_vld_d  = 1'b1;
              t_data_d = imem_data;
              t_pc_d   = pc_q;
            end
            if (halt_word || (pc_q == LAST_PC)) begin
              state_d = S_DRAIN;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (!h_vld_d) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A taken branch discards everything not already accepted by decode.
    if ((state_q != S_IDLE) && redirect_valid) begin
      h_vld_d = 1'b0;
      t_vld_d = 1'b0;
      pc_d    = redirect_pc;
      state_d = S_FETCH;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= START_PC;
      done_q   <= 1'b0;
      h_vld_q  <= 1'b0;
      h_data_q <= '0;
      h_pc_q   <= '0;
      t_vld_q  <= 1'b0;
      t_data_q <= '0;
      t_pc_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      done_q   <= done_d;
      h_vld_q  <= h_vld_d;
      h_data_q <= h_data_d;
      h_pc_q   <= h_pc_d;
      t_vld_q  <= t_vld_d;
      t_data_q <= t_data_d;
      t_pc_q   <= t_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_ok) begin
      cnt_d = '0;
    end else if (pop && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_count = cnt_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

  assign imem_addr  = pc_q;
  assign inst_valid = h_vld_q;
  assign inst       = h_data_q;
  assign inst_pc    = h_pc_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_inst_fetch_ctrl;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int LAST = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          inst_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          inst_valid;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          busy;
  logic          done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]   fetch_count;
`endif

  logic [DW-1:0] mem [0:255];
  assign imem_data = mem[imem_addr[7:0]];

  always #5 clk = ~clk;

  inst_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .done           (done)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: pending words as a queue, mode 0=idle 1=fetching 2=draining.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc;
  int            m_mode;
  bit            m_done;
  int            m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pc   = '0;
      m_mode = 0;
      m_done = 0;
      m_cnt  = 0;
    end else begin : step
      bit   pop;
      ent_t e;
      pop    = (mq.size() > 0) && inst_ready;
      m_done = 0;
      if (pop) begin
        void'(mq.pop_front());
        if (m_cnt < 65535) m_cnt++;
      end
      if (m_mode == 0) begin
        if (start) begin
          m_pc   = '0;
          m_mode = 1;
          m_cnt  = 0;
        end
      end else if (redirect_valid) begin
        mq.delete();
        m_pc   = redirect_pc;
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (m_pc > LAST) begin
          m_mode = 2;
        end else if (mq.size() < 2) begin
          e.pc   = m_pc;
          e.data = mem[m_pc[7:0]];
          mq.push_back(e);
          if (e.data[31:26] == 6'h3F || m_pc == LAST) m_mode = 2;
          else m_pc = m_pc + 1'b1;
        end
      end else begin
        if (mq.size() == 0) begin
          m_mode = 0;
          m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("inst_valid", inst_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("inst", inst, mq[0].data);
        check("inst_pc", inst_pc, mq[0].pc);
      end
      check("imem_addr", imem_addr, m_pc);
      check("busy", busy, m_mode != 0);
      check("done", done, m_done);
`ifdef FETCH_PERF_CNT_EN
      check("fetch_count", fetch_count, m_cnt);
`endif
    end
  end

  // Observation of what decode actually accepted, plus timing markers.
  logic [AW-1:0] plog[$];
  int            pcyc[$];
  int            cyc = 0;
  int            n_done = 0;
  int            done_cyc = 0;
  int            max_addr = 0;

  always @(posedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      plog.push_back(inst_pc);
      pcyc.push_back(cyc);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy && int'(imem_addr) > max_addr) max_addr = int'(imem_addr);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check({nm, "_timeout"}, busy, 1'b0);
    tick();
  endtask

  task automatic check_log(input string nm, input int exp_q[$]);
    check({nm, "_len"}, plog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < plog.size(); i++)
      check($sformatf("%s_%0d", nm, i), plog[i], exp_q[i]);
  endtask

  task automatic fill_plain();
    for (int i = 0; i < 256; i++)
      mem[i] = {6'($urandom_range(0, 62)), 26'($urandom)};
  endtask

  task automatic clear_obs();
    plog.delete();
    pcyc.delete();
    n_done = 0;
    max_addr = 0;
  endtask

  int seq11[$];
  int seq4[$];
  int seq_rd[$];

  initial begin
    for (int i = 0; i <= LAST; i++) seq11.push_back(i);
    seq4   = '{0, 1, 2, 3};
    seq_rd = '{0, 1, 8, 9, 10};
    fill_plain();

    // Reset values
    rst_n = 1'b0;
    tick();
    check("rst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_addr", imem_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full program, ready held high
    clear_obs();
    inst_ready = 1'b1;
    pulse_start();
    check("t1_first_invalid", inst_valid, 1'b0);
    check("t1_busy", busy, 1'b1);
    tick();
    check("t1_first_valid", inst_valid, 1'b1);
    check("t1_first_pc", inst_pc, 0);
    wait_idle("t1", 60);
    check_log("t1_log", seq11);
    check("t1_done_cnt", n_done, 1);
    if (pcyc.size() == 11) check("t1_back_to_back", pcyc[10] - pcyc[0], 10);
    else check("t1_pop_count", pcyc.size(), 11);

    // Halt opcode at address 3
    clear_obs();
    mem[3] = 32'hFC000000;
    pulse_start();
    wait_idle("t2", 60);
    check_log("t2_log", seq4);
    check("t2_max_addr", max_addr, 3);
    check("t2_done_cnt", n_done, 1);
    if (pcyc.size() == 4) check("t2_done_after_pop", done_cyc - pcyc[3], 1);
    else check("t2_pop_count", pcyc.size(), 4);
    mem[3] = 32'h00000003;

    // Back-pressure right after start
    clear_obs();
    inst_ready = 1'b0;
    pulse_start();
    repeat (4) tick();
    check("t3_addr_hold", imem_addr, 2);
    check("t3_head_pc", inst_pc, 0);
    check("t3_valid", inst_valid, 1'b1);
    inst_ready = 1'b1;
    wait_idle("t3", 60);
    check_log("t3_log", seq11);

    // Redirect to 8 while buffer holds 2,3
    clear_obs();
    inst_ready = 1'b1;
    pulse_start();
    begin
      int k = 0;
      while (!(inst_valid && inst_pc == 2) && k < 20) begin
        tick();
        k++;
      end
      check("t4_reach_pc2", inst_pc, 2);
    end
    inst_ready = 1'b0;
    tick();
    tick();
    check("t4_head_pc", inst_pc, 2);
    check("t4_addr", imem_addr, 4);
    redirect_valid = 1'b1;
    redirect_pc    = 16'd8;
    tick();
    redirect_valid = 1'b0;
    check("t4_flush_valid", inst_valid, 1'b0);
    inst_ready = 1'b1;
    wait_idle("t4", 60);
    check_log("t4_log", seq_rd);
    check("t4_done_cnt", n_done, 1);

    // Redirect beyond the program
    clear_obs();
    inst_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    inst_ready = 1'b0;
    begin
      int n_before;
      n_before       = plog.size();
      redirect_valid = 1'b1;
      redirect_pc    = 16'd20;
      tick();
      redirect_valid = 1'b0;
      inst_ready     = 1'b1;
      wait_idle("t5", 20);
      check("t5_nothing_more", plog.size(), n_before);
    end
    check("t5_done_cnt", n_done, 1);
    check("t5_busy", busy, 1'b0);

    // Asynchronous reset mid-fetch with two entries buffered
    inst_ready = 1'b0;
    pulse_start();
    repeat (3) tick();
    check("t6_pre_valid", inst_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", inst_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_addr", imem_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    clear_obs();
    inst_ready = 1'b1;
    pulse_start();
    wait_idle("t6", 60);
    check_log("t6_log", seq11);
`ifdef FETCH_PERF_CNT_EN
    check("t6_fetch_count", fetch_count, 11);
`endif

    // Randomized traffic against the model
    for (int run = 0; run < 12; run++) begin
      int nredir = 0;
      fill_plain();
      if ($urandom_range(0, 9) < 4)
        mem[$urandom_range(0, LAST)] = {6'h3F, 26'($urandom)};
      for (int c = 0; c < 150; c++) begin
        inst_ready     = ($urandom_range(0, 9) < 7);
        start          = ($urandom_range(0, 9) == 0);
        redirect_valid = (nredir < 3) && ($urandom_range(0, 19) == 0);
        redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'd20 : 16'($urandom_range(0, 12));
        if (redirect_valid && busy) nredir++;
        tick();
      end
      start          = 1'b0;
      redirect_valid = 1'b0;
      inst_ready     = 1'b1;
      wait_idle("rand", 60);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
